maskmul_sched: RTL and testbench

Round-robin scheduler sharing one masked GF(2^2) multiplier (`maskmul`) among `NREQ` requesters. It arbitrates operand requests and registers the winning operands onto the multiplier ports. For each operation it generates a fresh output mask `mq` from an internal LFSR and tracks in-flight operations through the multiplier's fixed latency. Tagged results are returned through a credit-protected result FIFO. It sits between the requester fabric and the single `maskmul` instance in the masked-arithmetic cluster.

---
 rtl/maskmul_sched.sv | 260 ++++++++++++++++++++++++++
 tb/tb_maskmul_sched.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/maskmul_sched.sv
// maskmul_fifo: generic first-word-fall-through FIFO with registered storage.
// Latency: a write is visible at the head on the cycle after the write edge.
// Backpressure: none internally; the writer must guarantee space (pop and write may coincide).
//
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   wr_vld, wr_dat    write strobe and data
//   rd_vld, rd_rdy    head valid / consumer pop request
//   rd_dat            head data (stable until popped)
module maskmul_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             rd_vld,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_pop;

    assign rd_vld = (count != '0);
    assign do_pop = rd_vld & rd_rdy;
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            // When full, a write only arrives together with a pop, so the
            // slot being overwritten is the head that leaves this cycle.
            if (wr_vld) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({wr_vld, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// maskmul_sched: round-robin scheduler sharing one masked GF(4) multiplier among NREQ requesters.
// Latency: handshake in cycle c -> mm_* in c+1 -> mm_qm sampled c+1+LAT -> rsp_valid from c+2+LAT.
// Backpressure: credits (in-flight + FIFO occupancy) gate req_ready; rsp_ready low stalls grants at FDEPTH.
//
// Ports:
//   clock, reset                         rising-edge clock, asynchronous active-high reset
//   req_valid / req_ready                per-requester request, one-hot grant
//   req_am, req_bm, req_ma, req_mb       2 bits per requester, requester i at [2i+1:2i]
//   mm_valid, mm_am/bm/ma/mb/mq          registered multiplier operands and fresh output mask
//   mm_qm                                multiplier result, valid LAT cycles after mm_valid
//   rsp_valid / rsp_ready                result FIFO head and pop
//   rsp_id, rsp_qm, rsp_mq               originating requester, masked result, its mask
module maskmul_sched #(
    parameter int         NREQ   = 4,
    parameter int         LAT    = 1,
    parameter int         FDEPTH = 4,
    parameter logic [7:0] SEED   = 8'hA5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [2*NREQ-1:0]    req_am,
    input  logic [2*NREQ-1:0]    req_bm,
    input  logic [2*NREQ-1:0]    req_ma,
    input  logic [2*NREQ-1:0]    req_mb,
    output logic                 mm_valid,
    output logic [1:0]           mm_am,
    output logic [1:0]           mm_bm,
    output logic [1:0]           mm_ma,
    output logic [1:0]           mm_mb,
    output logic [1:0]           mm_mq,
    input  logic [1:0]           mm_qm,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [1:0]           rsp_qm,
    output logic [1:0]           rsp_mq
);
    localparam int IDW  = $clog2(NREQ);
    localparam int CW   = $clog2(FDEPTH + 1);
    localparam int TAGW = IDW + 4;

    logic [7:0]      lfsr;
    logic [IDW-1:0]  ptr;
    logic [CW-1:0]   credit_used;
    logic            credit_ok;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  gidx;
    logic [IDW-1:0]  cand;
    logic            found;
    logic            accept;
    logic            pop;

    logic [1:0]      sel_am;
    logic [1:0]      sel_bm;
    logic [1:0]      sel_ma;
    logic [1:0]      sel_mb;

    // Tag pipeline: stage 0 lines up with mm_valid, stage LAT with mm_qm.
    logic            tag_vld [LAT+1];
    logic [IDW-1:0]  tag_id  [LAT+1];
    logic [1:0]      tag_mq  [LAT+1];

    logic [TAGW-1:0] fifo_wr_dat;
    logic [TAGW-1:0] fifo_rd_dat;

    // ------------------------------------------------------------------
    // Grant: first valid requester after ptr, only while a credit remains.
    // ------------------------------------------------------------------
    assign credit_ok = (credit_used < CW'(FDEPTH)) && !reset;

    always_comb begin
        grant = '0;
        gidx  = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'((int'(ptr) + 1 + k) % NREQ);
            if (!found && req_valid[cand]) begin
                grant[cand] = 1'b1;
                gidx        = cand;
                found       = 1'b1;
            end
        end
        if (!credit_ok) begin
            grant = '0;
        end
    end

    assign req_ready = grant;
    assign accept    = |(req_valid & grant);
    assign pop       = rsp_valid & rsp_ready;

    // Grant is one-hot, so an OR-mux picks the winner's operand fields.
    always_comb begin
        sel_am = '0;
        sel_bm = '0;
        sel_ma = '0;
        sel_mb = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_am = sel_am | req_am[2*i +: 2];
                sel_bm = sel_bm | req_bm[2*i +: 2];
                sel_ma = sel_ma | req_ma[2*i +: 2];
                sel_mb = sel_mb | req_mb[2*i +: 2];
            end
        end
    end

    // ------------------------------------------------------------------
    // Mask source: x^8+x^6+x^5+x^4+1 Fibonacci LFSR, free running.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr <= SEED;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    // ------------------------------------------------------------------
    // Pointer, credits and multiplier operand registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr         <= IDW'(NREQ - 1);
            credit_used <= '0;
            mm_valid    <= 1'b0;
            mm_am       <= '0;
            mm_bm       <= '0;
            mm_ma       <= '0;
            mm_mb       <= '0;
            mm_mq       <= '0;
        end else begin
            mm_valid <= accept;
            if (accept) begin
                ptr   <= gidx;
                mm_am <= sel_am;
                mm_bm <= sel_bm;
                mm_ma <= sel_ma;
                mm_mb <= sel_mb;
                mm_mq <= lfsr[1:0];
            end
            case ({accept, pop})
                2'b10:   credit_used <= credit_used + 1'b1;
                2'b01:   credit_used <= credit_used - 1'b1;
                default: credit_used <= credit_used;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Tag shift register tracking each operation through the multiplier.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k <= LAT; k++) begin
                tag_vld[k] <= 1'b0;
                tag_id[k]  <= '0;
                tag_mq[k]  <= '0;
            end
        end else begin
            tag_vld[0] <= accept;
            if (accept) begin
                tag_id[0] <= gidx;
                tag_mq[0] <= lfsr[1:0];
            end
            for (int k = 1; k <= LAT; k++) begin
                tag_vld[k] <= tag_vld[k-1];
                tag_id[k]  <= tag_id[k-1];
                tag_mq[k]  <= tag_mq[k-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Result FIFO: space was reserved by the credit taken at accept.
    // ------------------------------------------------------------------
    assign fifo_wr_dat = {tag_id[LAT], mm_qm, tag_mq[LAT]};

    maskmul_fifo #(
        .WIDTH (TAGW),
        .DEPTH (FDEPTH)
    ) u_rsp_fifo (
        .clock  (clock),
        .reset  (reset),
        .wr_vld (tag_vld[LAT]),
        .wr_dat (fifo_wr_dat),
        .rd_vld (rsp_valid),
        .rd_rdy (rsp_ready),
        .rd_dat (fifo_rd_dat)
    );

    assign rsp_id = fifo_rd_dat[TAGW-1:4];
    assign rsp_qm = fifo_rd_dat[3:2];
    assign rsp_mq = fifo_rd_dat[1:0];
endmodule

// File: tb/tb_maskmul_sched.sv
module tb_maskmul_sched;
    localparam int NREQ   = 4;
    localparam int LAT    = 1;
    localparam int FDEPTH = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req_valid = '0;
    logic [3:0] req_ready;
    logic [7:0] req_am, req_bm, req_ma, req_mb;
    logic       mm_valid;
    logic [1:0] mm_am, mm_bm, mm_ma, mm_mb, mm_mq;
    logic [1:0] mm_qm = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [1:0] rsp_id, rsp_qm, rsp_mq;

    int tests_run = 0;
    int tests_failed = 0;

    // Unmasked product per requester, worked by hand in GF(4) mod x^2+x+1:
    // r0: 1*2=2, r1: 2*2=3, r2: 2*3=1, r3: 3*3=2
    logic [1:0] exp_q [4] = '{2'd2, 2'd3, 2'd1, 2'd2};

    always #5 clock = ~clock;

    maskmul_sched #(.NREQ(NREQ), .LAT(LAT), .FDEPTH(FDEPTH), .SEED(8'hA5)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_am(req_am), .req_bm(req_bm), .req_ma(req_ma), .req_mb(req_mb),
        .mm_valid(mm_valid), .mm_am(mm_am), .mm_bm(mm_bm), .mm_ma(mm_ma),
        .mm_mb(mm_mb), .mm_mq(mm_mq), .mm_qm(mm_qm),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_qm(rsp_qm), .rsp_mq(rsp_mq)
    );

    // Reference masked multiplier, latency 1.
    function automatic logic [1:0] gf_mul(input logic [1:0] a, input logic [1:0] b);
        gf_mul = {(a[1] & b[1]) ^ (a[1] & b[0]) ^ (a[0] & b[1]), (a[1] & b[1]) ^ (a[0] & b[0])};
    endfunction

    always @(posedge clock) begin
        if (mm_valid) mm_qm <= gf_mul(mm_am ^ mm_ma, mm_bm ^ mm_mb) ^ mm_mq;
    end

    // Leaves the bench at a falling edge with reset just released.
    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; req_valid = '0; rsp_ready = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; rsp_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            req_valid = (i == 0) ? 4'b1111 : 4'b0000;
            #1;
            tests_run++;
            if ({req_ready, mm_valid, mm_am, mm_bm, mm_ma, mm_mb, mm_mq, rsp_valid, rsp_id, rsp_qm, rsp_mq} !== '0) begin
                tests_failed++;
                $display("FAIL reset_outputs: req_ready=%b mm_valid=%b mm=%h%h%h%h%h rsp=%b/%h/%h/%h required all 0",
                         req_ready, mm_valid, mm_am, mm_bm, mm_ma, mm_mb, mm_mq, rsp_valid, rsp_id, rsp_qm, rsp_mq);
            end
        end
        @(negedge clock);
        reset = 1'b0; req_valid = 4'b0100;
        #1;
        tests_run++;
        if (req_ready !== 4'b0100) begin
            tests_failed++; $display("FAIL reset_first_grant: got %b required 0100", req_ready);
        end
        @(negedge clock); #1;
        tests_run++;
        if (mm_valid !== 1'b1 || mm_mq !== 2'b01) begin
            tests_failed++; $display("FAIL reset_first_mask: mm_valid=%b mm_mq=%b required 1/01", mm_valid, mm_mq);
        end
        tests_run++;
        if (req_ready !== 4'b0100) begin
            tests_failed++; $display("FAIL reset_second_grant: got %b required 0100", req_ready);
        end
        @(negedge clock); #1;
        tests_run++;
        if (mm_valid !== 1'b1 || mm_mq !== 2'b10) begin
            tests_failed++; $display("FAIL reset_second_mask: mm_valid=%b mm_mq=%b required 1/10", mm_valid, mm_mq);
        end
        req_valid = '0;
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 4'b0100;
        #1;
        tests_run++;
        if (req_ready !== 4'b0100) begin
            tests_failed++; $display("FAIL single_grant: got %b required 0100", req_ready);
        end
        @(negedge clock);
        req_valid = '0;
        #1;
        tests_run++;
        if (mm_valid !== 1'b1 || {mm_am, mm_bm, mm_ma, mm_mb} !== 8'b11_00_01_11) begin
            tests_failed++; $display("FAIL single_operands: mm_valid=%b am/bm/ma/mb=%b%b%b%b required 1/11000111",
                                     mm_valid, mm_am, mm_bm, mm_ma, mm_mb);
        end
        for (int i = 0; i < 2; i++) begin
            tests_run++;
            if (rsp_valid !== 1'b0) begin
                tests_failed++; $display("FAIL single_early_rsp: cycle %0d rsp_valid=%b required 0", i + 1, rsp_valid);
            end
            @(negedge clock); #1;
        end
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || (rsp_qm ^ rsp_mq) !== 2'b01 || rsp_mq !== 2'b01) begin
            tests_failed++; $display("FAIL single_rsp: valid=%b id=%0d unmasked=%b mq=%b required 1/2/01/01",
                                     rsp_valid, rsp_id, rsp_qm ^ rsp_mq, rsp_mq);
        end
    endtask

    task automatic test_fairness();
        logic [3:0] exp_grant [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        int n = 0;
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            req_valid = (i < 6) ? 4'b1111 : 4'b0000;
            #1;
            if (i < 6) begin
                tests_run++;
                if (req_ready !== exp_grant[i]) begin
                    tests_failed++; $display("FAIL fair_grant[%0d]: got %b required %b", i, req_ready, exp_grant[i]);
                end
            end
            if (rsp_valid && n < 6) begin
                tests_run++;
                if (rsp_id !== 2'(n % 4) || (rsp_qm ^ rsp_mq) !== exp_q[n % 4]) begin
                    tests_failed++; $display("FAIL fair_rsp[%0d]: id=%0d unmasked=%0d required %0d/%0d",
                                             n, rsp_id, rsp_qm ^ rsp_mq, n % 4, exp_q[n % 4]);
                end
                n++;
            end
            @(negedge clock);
        end
        tests_run++;
        if (n != 6) begin
            tests_failed++; $display("FAIL fair_rsp_count: got %0d required 6", n);
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int acc = 0;
        do_reset();
        rsp_ready = 1'b0; req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (req_ready != 4'b0000) acc++;
            @(negedge clock);
        end
        #1;
        tests_run++;
        if (acc != 4 || req_ready !== 4'b0000) begin
            tests_failed++; $display("FAIL bp_accepts: accepts=%0d req_ready=%b required 4/0000", acc, req_ready);
        end
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin
            tests_failed++; $display("FAIL bp_head: valid=%b id=%0d required 1/0", rsp_valid, rsp_id);
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        #1;
        tests_run++;
        if (req_ready !== 4'b0001 || rsp_id !== 2'd1) begin
            tests_failed++; $display("FAIL bp_after_pop: req_ready=%b id=%0d required 0001/1", req_ready, rsp_id);
        end
        @(negedge clock); #1;
        tests_run++;
        if (req_ready !== 4'b0000 || rsp_id !== 2'd1) begin
            tests_failed++; $display("FAIL bp_refull: req_ready=%b id=%0d required 0000/1", req_ready, rsp_id);
        end
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        int acc = 0;
        do_reset();
        rsp_ready = 1'b0; req_valid = 4'b0001;
        repeat (3) @(negedge clock);
        req_valid = '0;
        #1;
        tests_run++;
        if (rsp_valid !== 1'b1 || dut.credit_used !== 3'd3) begin
            tests_failed++; $display("FAIL mid_setup: rsp_valid=%b credit=%0d required 1/3", rsp_valid, dut.credit_used);
        end
        reset = 1'b1; req_valid = 4'b1111;
        #1;
        tests_run++;
        if (rsp_valid !== 1'b0 || mm_valid !== 1'b0 || req_ready !== 4'b0000) begin
            tests_failed++; $display("FAIL mid_reset_outputs: rsp_valid=%b mm_valid=%b req_ready=%b required 0/0/0000",
                                     rsp_valid, mm_valid, req_ready);
        end
        req_valid = '0;
        @(negedge clock);
        reset = 1'b0; rsp_ready = 1'b1;
        for (int i = 0; i < LAT + 4; i++) begin
            #1;
            if (rsp_valid) seen++;
            @(negedge clock);
        end
        tests_run++;
        if (seen != 0) begin
            tests_failed++; $display("FAIL mid_stale_rsp: got %0d responses required 0", seen);
        end
        rsp_ready = 1'b0; req_valid = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (req_ready != 4'b0000) acc++;
            @(negedge clock);
        end
        tests_run++;
        if (acc != 4) begin
            tests_failed++; $display("FAIL mid_new_accepts: got %0d required 4", acc);
        end
        req_valid = '0;
    endtask

    task automatic test_simultaneous();
        do_reset();
        rsp_ready = 1'b0; req_valid = 4'b1111;
        repeat (6) @(negedge clock);
        #1;
        tests_run++;
        if (dut.credit_used !== 3'd4 || req_ready !== 4'b0000) begin
            tests_failed++; $display("FAIL simul_full: credit=%0d req_ready=%b required 4/0000", dut.credit_used, req_ready);
        end
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) #1;
            tests_run++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'(i % 4) || (rsp_qm ^ rsp_mq) !== exp_q[i % 4]) begin
                tests_failed++; $display("FAIL simul_rsp[%0d]: valid=%b id=%0d unmasked=%0d required 1/%0d/%0d",
                                         i, rsp_valid, rsp_id, rsp_qm ^ rsp_mq, i % 4, exp_q[i % 4]);
            end
            tests_run++;
            if (dut.credit_used !== ((i == 0) ? 3'd4 : 3'd3)) begin
                tests_failed++; $display("FAIL simul_credit[%0d]: got %0d required %0d", i, dut.credit_used, (i == 0) ? 4 : 3);
            end
            if (i > 0) begin
                tests_run++;
                if (req_ready !== 4'(1 << ((i - 1) % 4))) begin
                    tests_failed++; $display("FAIL simul_grant[%0d]: got %b required %b", i, req_ready, 4'(1 << ((i - 1) % 4)));
                end
            end
            @(negedge clock);
        end
        req_valid = '0; rsp_ready = 1'b0;
    endtask

    initial begin
        req_am = {2'd0, 2'd3, 2'd3, 2'd1};
        req_ma = {2'd3, 2'd1, 2'd1, 2'd0};
        req_bm = {2'd1, 2'd0, 2'd2, 2'd2};
        req_mb = {2'd2, 2'd3, 2'd0, 2'd0};
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_reset_mid();
        test_simultaneous();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
